// File: rtl/traffic_phase_sched.sv
// -----------------------------------------------------------------------------
// traffic_phase_sched
//
// Demand-driven phase scheduler for a two-road (north/east) intersection.
// The scheduler steps both lamp sets through green, yellow and all-red phases.
// Each green has a minimum and a maximum length. A green is extended while
// its own approach keeps calling, and it ends early (gap-out) once that
// approach goes quiet and the other side has demand. An optional pedestrian
// walk phase is slotted in after an all-red clearance.
//
// Optional feature macro: TRAFFIC_SCHED_PED_EN
//   defined   -> pedestrian latch, WALK phase and walk-source register present
//   undefined -> PED_REQ ignored, PED_PEND/WALK tied low, AR1->EG, AR2->NG
//
// Parameters
//   GREEN_MIN  minimum green cycles per approach (>=1)
//   GREEN_MAX  maximum green cycles while the other side has demand
//   YELLOW_T   yellow duration in cycles
//   ALLRED_T   all-red clearance in cycles
//   WALK_T     pedestrian walk duration in cycles
//   CW         timer width, must hold the largest duration minus one
//
// Ports
//   CLK        in   clock, rising edge
//   CLR_N      in   synchronous active-low reset
//   CAR_N      in   vehicle present on north approach (level)
//   CAR_E      in   vehicle present on east approach (level)
//   PED_REQ    in   pedestrian button (pulse or level)
//   GN/YN/RN   out  north green / yellow / red
//   GE/YE/RE   out  east green / yellow / red
//   WALK       out  pedestrian walk lamp
//   PED_PEND   out  pedestrian request latched, not yet served
//   PHASE[2:0] out  current state encoding (NG=0 .. WALK=6)
// -----------------------------------------------------------------------------
module traffic_phase_sched #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 40,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 8,
    parameter int CW        = 8
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       CAR_N,
    input  logic       CAR_E,
    input  logic       PED_REQ,
    output logic       GN,
    output logic       YN,
    output logic       RN,
    output logic       GE,
    output logic       YE,
    output logic       RE,
    output logic       WALK,
    output logic       PED_PEND,
    output logic [2:0] PHASE
);

    typedef enum logic [2:0] {
        ST_NG   = 3'd0,
        ST_NY   = 3'd1,
        ST_AR1  = 3'd2,
        ST_EG   = 3'd3,
        ST_EY   = 3'd4,
        ST_AR2  = 3'd5,
        ST_WALK = 3'd6
    } state_t;

    // Terminal timer values (duration - 1) at the timer width.
    localparam logic [CW-1:0] GMIN_LAST   = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST   = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_T - 1);

    // Lamp vector order: {GN, YN, RN, GE, YE, RE}
    localparam logic [5:0] LAMPS_NG  = 6'b100_001;
    localparam logic [5:0] LAMPS_NY  = 6'b010_001;
    localparam logic [5:0] LAMPS_EG  = 6'b001_100;
    localparam logic [5:0] LAMPS_EY  = 6'b001_010;
    localparam logic [5:0] LAMPS_RED = 6'b001_001;

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [5:0]    lamp_q;
    logic          leave_ng_demand;   // opposing demand seen from NG
    logic          leave_eg_demand;   // opposing demand seen from EG
    logic          in_green;

    function automatic logic [5:0] lamp_decode(input state_t s);
        logic [5:0] l;
        l = LAMPS_RED;
        case (s)
            ST_NG:   l = LAMPS_NG;
            ST_NY:   l = LAMPS_NY;
            ST_EG:   l = LAMPS_EG;
            ST_EY:   l = LAMPS_EY;
            default: l = LAMPS_RED;
        endcase
        return l;
    endfunction

`ifdef TRAFFIC_SCHED_PED_EN
    localparam logic [CW-1:0] WALK_LAST = CW'(WALK_T - 1);

    logic ped_pend_q, ped_pend_d;
    logic walk_src_q, walk_src_d;     // 0: WALK entered from AR1, 1: from AR2
    logic walk_q;
    logic entering_walk;

    assign leave_ng_demand = CAR_E | ped_pend_q;
    assign leave_eg_demand = CAR_N | ped_pend_q;
    assign entering_walk   = (state_d == ST_WALK) && (state_q != ST_WALK);

    always_comb begin
        ped_pend_d = ped_pend_q;
        walk_src_d = walk_src_q;
        if (PED_REQ && (state_q != ST_WALK)) begin
            ped_pend_d = 1'b1;
        end
        // Entering WALK serves the request; a press on that same edge is
        // considered served too, so the clear takes priority.
        if (entering_walk) begin
            ped_pend_d = 1'b0;
            walk_src_d = (state_q == ST_AR2);
        end
    end
`else
    logic ped_req_unused;

    assign ped_req_unused  = PED_REQ;
    assign leave_ng_demand = CAR_E;
    assign leave_eg_demand = CAR_N;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Leave green after the minimum time if the other side is waiting
            // and either this side went quiet (gap-out) or max-out was reached.
            ST_NG: begin
                if ((timer_q >= GMIN_LAST) && leave_ng_demand &&
                    (!CAR_N || (timer_q == GMAX_LAST))) begin
                    state_d = ST_NY;
                end
            end
            ST_NY: begin
                if (timer_q == YELLOW_LAST) begin
                    state_d = ST_AR1;
                end
            end
            ST_AR1: begin
                if (timer_q == ALLRED_LAST) begin
`ifdef TRAFFIC_SCHED_PED_EN
                    state_d = ped_pend_q ? ST_WALK : ST_EG;
`else
                    state_d = ST_EG;
`endif
                end
            end
            ST_EG: begin
                if ((timer_q >= GMIN_LAST) && leave_eg_demand &&
                    (!CAR_E || (timer_q == GMAX_LAST))) begin
                    state_d = ST_EY;
                end
            end
            ST_EY: begin
                if (timer_q == YELLOW_LAST) begin
                    state_d = ST_AR2;
                end
            end
            ST_AR2: begin
                if (timer_q == ALLRED_LAST) begin
`ifdef TRAFFIC_SCHED_PED_EN
                    state_d = ped_pend_q ? ST_WALK : ST_NG;
`else
                    state_d = ST_NG;
`endif
                end
            end
`ifdef TRAFFIC_SCHED_PED_EN
            ST_WALK: begin
                if (timer_q == WALK_LAST) begin
                    state_d = walk_src_q ? ST_NG : ST_EG;
                end
            end
`endif
            // Illegal (and, without the pedestrian feature, unused) codes
            // recover straight to north green.
            default: state_d = ST_NG;
        endcase
    end

    assign in_green = (state_q == ST_NG) || (state_q == ST_EG);

    // Timer restarts on every state entry; in green it parks at the max-out
    // value so a long rest never wraps and max-out stays immediately available.
    always_comb begin
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (in_green && (timer_q == GMAX_LAST)) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state_q <= ST_NG;
            timer_q <= '0;
            lamp_q  <= LAMPS_NG;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            // Lamps are registered from the next state, so they always match
            // the state register.
            lamp_q  <= lamp_decode(state_d);
        end
    end

`ifdef TRAFFIC_SCHED_PED_EN
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            ped_pend_q <= 1'b0;
            walk_src_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
            walk_src_q <= walk_src_d;
            walk_q     <= (state_d == ST_WALK);
        end
    end

    assign WALK     = walk_q;
    assign PED_PEND = ped_pend_q;
`else
    assign WALK     = 1'b0;
    assign PED_PEND = 1'b0;
`endif

    assign {GN, YN, RN, GE, YE, RE} = lamp_q;
    assign PHASE = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_phase_sched (GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2,
// ALLRED_T=1, WALK_T=4, CW=4). The stimulus process drives one clock cycle per
// step and queues the hand-computed phase and pending flag expected after that
// edge. A separate monitor pops each entry on the falling edge and checks
// PHASE, the lamp set and PED_PEND.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sched;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       CAR_N = 1'b0;
    logic       CAR_E = 1'b0;
    logic       PED_REQ = 1'b0;
    logic       GN, YN, RN, GE, YE, RE, WALK, PED_PEND;
    logic [2:0] PHASE;

    traffic_phase_sched #(
        .GREEN_MIN(3),
        .GREEN_MAX(6),
        .YELLOW_T (2),
        .ALLRED_T (1),
        .WALK_T   (4),
        .CW       (4)
    ) dut (
        .CLK     (CLK),
        .CLR_N   (CLR_N),
        .CAR_N   (CAR_N),
        .CAR_E   (CAR_E),
        .PED_REQ (PED_REQ),
        .GN      (GN),
        .YN      (YN),
        .RN      (RN),
        .GE      (GE),
        .YE      (YE),
        .RE      (RE),
        .WALK    (WALK),
        .PED_PEND(PED_PEND),
        .PHASE   (PHASE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         id;
        logic [2:0] ph;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;

    // Expected lamps {GN,YN,RN,GE,YE,RE,WALK} for each phase code.
    function automatic logic [6:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 7'b100_001_0;
            3'd1:    return 7'b010_001_0;
            3'd3:    return 7'b001_100_0;
            3'd4:    return 7'b001_010_0;
            3'd6:    return 7'b001_001_1;
            default: return 7'b001_001_0;
        endcase
    endfunction

    task automatic chk(input string nm, input int id, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", nm, id, got, want);
        end
    endtask

    // One clock cycle: apply inputs, let the edge happen, queue the expectation.
    task automatic step(input logic clr, input logic cn, input logic ce, input logic pr,
                        input logic [2:0] ph, input logic pend);
        exp_t e;
        CLR_N   = clr;
        CAR_N   = cn;
        CAR_E   = ce;
        PED_REQ = pr;
        @(posedge CLK);
        e.id   = step_no;
        e.ph   = ph;
        e.pend = pend;
        exp_q.push_back(e);
        step_no++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    // Monitor: the DUT presents a new state every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("phase", e.id, {4'd0, PHASE}, {4'd0, e.ph});
                chk("lamps", e.id, {GN, YN, RN, GE, YE, RE, WALK}, lamps_for(e.ph));
                chk("ped_pend", e.id, {6'd0, PED_PEND}, {6'd0, e.pend});
                $display("step %0d phase=%0d lamps=%b ped_pend=%0d", e.id, PHASE,
                         {GN, YN, RN, GE, YE, RE, WALK}, PED_PEND);
            end
        end
    end

    // Both approaches calling: every green maxes out.
    // NG 6, NY 2, AR1 1, EG 6, EY 2, AR2 1 -> 18-cycle repeat.
    logic [2:0] cyc_pat [18] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                                 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};

    initial begin
        @(negedge CLK);

        // Idle after reset: north green rests forever.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // East demand only: minimum green, yellow, clearance, then east green rests.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);

        // Both demands held: max-out cycling.
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, 1'b0, cyc_pat[(i + 1) % 18], 1'b0);

        // Gap-out at timer 3, then demand vanishes during yellow (no abort).
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);

        // Long north rest (timer parks at max), then east arrives: immediate max-out.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);

`ifdef TRAFFIC_SCHED_PED_EN
        // Pedestrian after north green, press on WALK entry and during WALK,
        // then a second request served after east green (AR2 -> WALK -> NG).
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Reset in the second WALK cycle aborts straight to north green.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Reset clears a latched request.
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
`else
        // Pedestrian button ignored while the feature is absent.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, (i % 5) == 0, 3'd0, 1'b0);

        // Button held with east demand: AR1 still goes straight to EG.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
`endif

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
